// File: rtl/msu_audio_seq.sv
// -----------------------------------------------------------------------------
// msu_audio_seq
//
// Sequences MSU-1 audio streaming between the MSU register block and the HPS
// command bridge. A play pulse requests a track and waits for the bridge to
// mount it. It then issues one sector request at a time whenever the audio
// FIFO can hold a whole sector. At end of track it either seeks back to the
// loop sector or stops.
//
// Ports:
//   clk_sys             system clock
//   reset               asynchronous active-high reset
//   play / stop         one-cycle command pulses (play wins when both are set)
//   repeat_en           loop at end of track (sampled at end of track)
//   track_num           track to play, latched on play
//   loop_sector         sector to seek to when looping
//   fifo_free           free 16-bit words in the audio FIFO
//   msu_track_num       latched track number presented to the bridge
//   msu_track_request   level track request to the bridge
//   msu_track_mounting  bridge is busy mounting the track
//   msu_track_missing   bridge could not find the track
//   msu_audio_size      track size in bytes, valid after mount
//   msu_audio_req       next-sector request
//   msu_audio_seek      one-cycle seek request
//   msu_audio_sector    seek target sector
//   msu_audio_ack       bridge acknowledge, high while downloading
//   msu_audio_download  sector data transfer active
//   playing             streaming active
//   track_missing       sticky until the next play
//   track_end           one-cycle pulse when a non-repeating track finishes
//   timeout_err         sticky until the next play
// -----------------------------------------------------------------------------
module msu_audio_seq #(
    parameter int          SECTOR_WORDS = 1024,
    parameter int          FIFO_AW      = 12,
    parameter logic [23:0] TIMEOUT      = 24'hFFFFFF
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               play,
    input  logic               stop,
    input  logic               repeat_en,
    input  logic [15:0]        track_num,
    input  logic [21:0]        loop_sector,
    input  logic [FIFO_AW-1:0] fifo_free,
    output logic [15:0]        msu_track_num,
    output logic               msu_track_request,
    input  logic               msu_track_mounting,
    input  logic               msu_track_missing,
    input  logic [31:0]        msu_audio_size,
    output logic               msu_audio_req,
    output logic               msu_audio_seek,
    output logic [21:0]        msu_audio_sector,
    input  logic               msu_audio_ack,
    input  logic               msu_audio_download,
    output logic               playing,
    output logic               track_missing,
    output logic               track_end,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TREQ,
        ST_MOUNT,
        ST_FILL,
        ST_REQ,
        ST_DL,
        ST_END,
        ST_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] track_num_q, track_num_d;
    logic        track_req_q, track_req_d;
    logic        audio_req_q, audio_req_d;
    logic        audio_seek_q, audio_seek_d;
    logic [21:0] audio_sector_q, audio_sector_d;
    logic        playing_q, playing_d;
    logic        track_missing_q, track_missing_d;
    logic        track_end_q, track_end_d;
    logic        timeout_err_q, timeout_err_d;
    logic [21:0] total_q, total_d;
    logic [21:0] sec_cnt_q, sec_cnt_d;
    logic [23:0] timer_q, timer_d;
    logic        ack_prev_q, ack_prev_d;
    logic        dl_prev_q, dl_prev_d;
    logic        restart_q, restart_d;

    logic        ack_rise;
    logic        dl_rise;
    logic        dl_fall;
    logic        space_ok;
    logic        counting;
    logic        busy_cmd;
    logic [21:0] total_calc;

    // Edge detectors on the bridge handshake. A stale ack left over from the
    // previous sector cannot complete a fresh request.
    assign ack_rise = msu_audio_ack && !ack_prev_q;
    assign dl_rise  = msu_audio_download && !dl_prev_q;
    assign dl_fall  = !msu_audio_download && dl_prev_q;

    assign space_ok = (fifo_free >= FIFO_AW'(SECTOR_WORDS));

    // Only states that wait on the bridge run the watchdog.
    assign counting = (state_q == ST_TREQ) || (state_q == ST_MOUNT) ||
                      (state_q == ST_REQ)  || (state_q == ST_DL);

    assign busy_cmd = (state_q != ST_IDLE) && (play || stop);

    // Sector count rounded up. size[31:11] is at most 21 bits, so adding
    // one more sector always fits in 22 bits and cannot overflow.
    assign total_calc = {1'b0, msu_audio_size[31:11]} +
                        {21'd0, |msu_audio_size[10:0]};

    // State register: every flop of the sequencer, cleared asynchronously.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            track_num_q     <= '0;
            track_req_q     <= 1'b0;
            audio_req_q     <= 1'b0;
            audio_seek_q    <= 1'b0;
            audio_sector_q  <= '0;
            playing_q       <= 1'b0;
            track_missing_q <= 1'b0;
            track_end_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
            total_q         <= '0;
            sec_cnt_q       <= '0;
            timer_q         <= '0;
            ack_prev_q      <= 1'b0;
            dl_prev_q       <= 1'b0;
            restart_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            track_num_q     <= track_num_d;
            track_req_q     <= track_req_d;
            audio_req_q     <= audio_req_d;
            audio_seek_q    <= audio_seek_d;
            audio_sector_q  <= audio_sector_d;
            playing_q       <= playing_d;
            track_missing_q <= track_missing_d;
            track_end_q     <= track_end_d;
            timeout_err_q   <= timeout_err_d;
            total_q         <= total_d;
            sec_cnt_q       <= sec_cnt_d;
            timer_q         <= timer_d;
            ack_prev_q      <= ack_prev_d;
            dl_prev_q       <= dl_prev_d;
            restart_q       <= restart_d;
        end
    end

    // Next-state logic. The per-state behaviour is resolved first. The
    // watchdog abort, stop and play-while-busy then override it in
    // increasing priority, so play always wins over stop and over a
    // timeout in the same cycle.
    always_comb begin
        state_d         = state_q;
        track_num_d     = track_num_q;
        track_req_d     = track_req_q;
        audio_req_d     = audio_req_q;
        audio_seek_d    = 1'b0;
        audio_sector_d  = audio_sector_q;
        playing_d       = playing_q;
        track_missing_d = track_missing_q;
        track_end_d     = 1'b0;
        timeout_err_d   = timeout_err_q;
        total_d         = total_q;
        sec_cnt_d       = sec_cnt_q;
        restart_d       = restart_q;
        ack_prev_d      = msu_audio_ack;
        dl_prev_d       = msu_audio_download;

        case (state_q)
            ST_IDLE: begin
                if (play) begin
                    track_num_d     = track_num;
                    track_missing_d = 1'b0;
                    timeout_err_d   = 1'b0;
                    track_req_d     = 1'b1;
                    state_d         = ST_TREQ;
                end
            end

            ST_TREQ: begin
                if (msu_track_mounting) begin
                    state_d = ST_MOUNT;
                end
            end

            ST_MOUNT: begin
                if (!msu_track_mounting) begin
                    track_req_d = 1'b0;
                    if (msu_track_missing) begin
                        track_missing_d = 1'b1;
                        state_d         = ST_IDLE;
                    end else begin
                        total_d   = total_calc;
                        sec_cnt_d = '0;
                        playing_d = 1'b1;
                        state_d   = (total_calc == '0) ? ST_END : ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                // The bridge ignores sector requests while a track request
                // is up, so never raise one in that window.
                if (sec_cnt_q == total_q) begin
                    state_d = ST_END;
                end else if (space_ok && !track_req_q) begin
                    audio_req_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end

            ST_REQ: begin
                if (ack_rise || dl_rise) begin
                    audio_req_d = 1'b0;
                    state_d     = ST_DL;
                end
            end

            ST_DL: begin
                if (dl_fall) begin
                    sec_cnt_d = sec_cnt_q + 22'd1;
                    state_d   = ST_FILL;
                end
            end

            ST_END: begin
                if (repeat_en && (loop_sector < total_q)) begin
                    audio_sector_d = loop_sector;
                    sec_cnt_d      = loop_sector;
                    audio_seek_d   = 1'b1;
                    state_d        = ST_FILL;
                end else begin
                    track_end_d = 1'b1;
                    playing_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // The sector in flight is discarded, so sec_cnt is left alone.
                if (!msu_audio_download) begin
                    if (restart_q) begin
                        restart_d   = 1'b0;
                        track_req_d = 1'b1;
                        state_d     = ST_TREQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (counting && (timer_q == '0)) begin
            timeout_err_d = 1'b1;
            track_req_d   = 1'b0;
            audio_req_d   = 1'b0;
            audio_seek_d  = 1'b0;
            playing_d     = 1'b0;
            state_d       = ST_IDLE;
        end

        // A busy play is a stop plus a restart. Routing it through DRAIN
        // gives the bridge at least one cycle with the track request low
        // before the new track is requested.
        if (busy_cmd) begin
            track_req_d  = 1'b0;
            audio_req_d  = 1'b0;
            audio_seek_d = 1'b0;
            playing_d    = 1'b0;
            track_end_d  = 1'b0;
            restart_d    = play;
            if (play) begin
                track_num_d     = track_num;
                track_missing_d = 1'b0;
                timeout_err_d   = 1'b0;
                state_d         = ST_DRAIN;
            end else if ((state_q == ST_DL) || (state_q == ST_DRAIN)) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // The watchdog reloads with TIMEOUT-1 on every state change. The
        // abort then lands exactly TIMEOUT cycles after the state was entered.
        if (state_d != state_q) begin
            timer_d = TIMEOUT - 24'd1;
        end else if (counting) begin
            timer_d = timer_q - 24'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Output logic: every output comes straight from a flop, so the bridge
    // sees glitch-free levels.
    always_comb begin
        msu_track_num     = track_num_q;
        msu_track_request = track_req_q;
        msu_audio_req     = audio_req_q;
        msu_audio_seek    = audio_seek_q;
        msu_audio_sector  = audio_sector_q;
        playing           = playing_q;
        track_missing     = track_missing_q;
        track_end         = track_end_q;
        timeout_err       = timeout_err_q;
    end

endmodule

// File: doc/msu_audio_seq.md
Name: msu_audio_seq

Overview:
- Sequences MSU-1 audio streaming between the MSU register block and the HPS command bridge (track request, sector request, seek, download handshake).
- On a play command: requests the track, waits for mount, then issues sector requests whenever the audio FIFO has room for a full sector.
- Tracks end-of-track, and either loops via seek (repeat) or stops.
- Sits in the SNES MSU path, in clk_sys, between the MSU register/audio FIFO logic and the HPS extension bridge.

Parameters:
- SECTOR_WORDS, 1024: 16-bit FIFO words delivered per 2048-byte sector.
- FIFO_AW, 12: width of the fifo_free count.
- TIMEOUT, 24'hFFFFFF: clk_sys cycles allowed for any HPS response before abort.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous active-high reset
- play  in  1  one-cycle pulse: start track_num from sector 0
- stop  in  1  one-cycle pulse: halt streaming
- repeat  in  1  loop at end of track (sampled at end of track)
- track_num  in  16  track to play (latched on play)
- loop_sector  in  22  sector to seek to on loop
- fifo_free  in  FIFO_AW  free words in the audio FIFO
- msu_track_num  out  16  latched track number
- msu_track_request  out  1  level request to the bridge
- msu_track_mounting  in  1  bridge busy mounting
- msu_track_missing  in  1  track not found
- msu_audio_size  in  32  track size in bytes (valid after mount)
- msu_audio_req  out  1  next-sector request
- msu_audio_seek  out  1  seek request
- msu_audio_sector  out  22  seek target
- msu_audio_ack  in  1  bridge acknowledge; high while downloading
- msu_audio_download  in  1  sector data transfer active
- playing  out  1  streaming active
- track_missing  out  1  sticky until the next play
- track_end  out  1  one-cycle pulse when a non-repeating track finishes
- timeout_err  out  1  sticky until the next play

Behaviour:
- Reset (async) values:
  - All outputs 0.
  - State IDLE.
  - Counters 0.
- States:
  - IDLE: on play, latch track_num, clear track_missing and timeout_err, enter TREQ.
  - TREQ: assert msu_track_request; move to MOUNT once msu_track_mounting is seen high.
  - MOUNT: hold msu_track_request until msu_track_mounting falls, then deassert it.
    - If msu_track_missing: set track_missing, go to IDLE.
    - Otherwise: total = (msu_audio_size+2047)>>11 (22 bits, saturating); sec_cnt = 0; playing = 1.
    - If total == 0, go to END; otherwise go to FILL.
  - FILL: if sec_cnt == total, go to END. Else, if fifo_free >= SECTOR_WORDS, assert msu_audio_req and go to REQ.
  - REQ: hold msu_audio_req until msu_audio_ack or msu_audio_download rises, then drop it and go to DL.
  - DL: on the falling edge of msu_audio_download, sec_cnt++, go to FILL.
  - END:
    - If repeat and loop_sector < total: msu_audio_sector = loop_sector; sec_cnt = loop_sector; assert msu_audio_seek for one cycle; go to FILL.
    - Otherwise: pulse track_end, clear playing, go to IDLE.
- Latency: msu_audio_req rises the cycle after FILL sees sufficient space. Successive requests are separated by at least one download.
- Timeout:
  - Counter reloads on every state change.
  - In TREQ, MOUNT, REQ and DL it counts down; at 0, set timeout_err, drop all requests, clear playing, go to IDLE.
- stop in any state other than IDLE:
  - Drop msu_track_request, msu_audio_req and msu_audio_seek the next cycle; clear playing.
  - If in DL, wait in DRAIN for msu_audio_download to fall (no sec_cnt increment), then go to IDLE. Otherwise go directly to IDLE.
- play while not IDLE: treated as stop followed by a restart.
  - The new track_num is latched immediately.
  - After DRAIN where needed, enter TREQ.
- Simultaneous play and stop: play wins.
- Requests are never asserted while msu_track_request is high; the bridge drops them in that case.
- Reset mid-transfer: returns to IDLE with no pending request. The bridge clears its own ack.

Test Plan:
- Normal play:
  - Stimulus: play track 5; mounting high for 10 cycles; size = 6144; fifo_free = 2048.
  - Required: msu_track_num = 5, then exactly 3 msu_audio_req pulses; track_end pulses once after the 3rd download falls; playing = 0.
- Missing track:
  - Stimulus: msu_track_missing = 1 at mount end.
  - Required: track_missing = 1, no msu_audio_req, state IDLE.
- Repeat:
  - Stimulus: size = 8192, loop_sector = 1, repeat = 1.
  - Required: after sector 3 downloads, one-cycle msu_audio_seek with msu_audio_sector = 1; requests resume; 3 more requests before the next loop.
- Backpressure:
  - Stimulus: fifo_free = 1023.
  - Required: no request.
  - Stimulus: raise fifo_free to 1024.
  - Required: msu_audio_req the next cycle.
- Stop mid-download:
  - Stimulus: stop while msu_audio_download = 1.
  - Required: playing = 0 the next cycle; no new request after download falls; sec_cnt unchanged.
- Timeout:
  - Stimulus: TIMEOUT = 100; msu_audio_ack never arrives.
  - Required: timeout_err = 1 at cycle 100; msu_audio_req = 0; state IDLE.
